// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- multi-cycle ALU: single-cycle simple ops plus iterative unsigned
// multiply (shift-add) and divide (restoring) behind a start/busy/done handshake.
//
// Optional feature macro: SEQ_ALU_DIV_EN
//   defined   : DIV state and divider datapath are built; op 111 = divu.
//   undefined : no divider; op 111 completes like a simple op with zero results.
//
// Parameters
//   WIDTH        operand/result width (power of two, >= 4)
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      synchronous active-low reset
//   start_i      request, accepted only while busy_o = 0
//   op_i[2:0]    000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra,
//                110 mulu, 111 divu
//   a_i, b_i     operands, captured on acceptance
//   busy_o       iterative op in progress
//   done_o       one-cycle pulse; results valid from this cycle on
//   result_o     ALU value, product low half, or quotient
//   result_hi_o  product high half or remainder; 0 for simple ops
//   zero_o       registered (result_o == 0), updated with done_o
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             zero_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] CNT_END = CW'(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [1:0] S_DIV  = 2'd2;
`endif

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [2:0] OP_DIV = 3'b111;
`endif

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    // opnd_q holds the multiplicand (mul) or the divisor (div).
    logic [WIDTH-1:0] opnd_q,   opnd_d;
    // hi_q/lo_q form the double-width working register:
    //   mul: partial product high / remaining multiplier bits + product low
    //   div: partial remainder   / remaining dividend bits  + quotient
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             zero_q,   zero_d;
    logic             done_q,   done_d;

    // ---------------------------------------------------------------- simple ops
    // Shift amount is the full b value: any bit at or above SHW means the
    // shift goes past the operand width.
    logic             shift_big;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] simple_res;

    assign shift_big = |b_i[WIDTH-1:SHW];
    assign shamt     = b_i[SHW-1:0];

    always_comb begin
        simple_res = '0;
        case (op_i)
            OP_ADD: simple_res = a_i + b_i;
            OP_SUB: simple_res = a_i - b_i;
            OP_AND: simple_res = a_i & b_i;
            OP_OR:  simple_res = a_i | b_i;
            OP_SRL: simple_res = shift_big ? '0 : (a_i >> shamt);
            OP_SRA: simple_res = shift_big ? {WIDTH{a_i[WIDTH-1]}}
                                           : WIDTH'($signed(a_i) >>> shamt);
            default: simple_res = '0;
        endcase
    end

    // ---------------------------------------------------------------- mul step
    // Add the multiplicand into the high half when the current multiplier LSB
    // is set, then shift the whole {carry, hi, lo} right by one. The product
    // low bits enter lo from the top as the multiplier bits leave the bottom.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;

    assign mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
    // ---------------------------------------------------------------- div step
    // Shift the next dividend bit into the partial remainder; subtract the
    // divisor when it fits and shift the resulting quotient bit into lo.
    // With a zero divisor the compare always succeeds, so the quotient comes
    // out all ones and the remainder ends up equal to the dividend.
    logic [WIDTH:0]   div_r;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_n;
    logic [WIDTH-1:0] div_lo_n;

    assign div_r    = {hi_q, lo_q[WIDTH-1]};
    assign div_ge   = (div_r >= {1'b0, opnd_q});
    // The true difference is below the divisor, so the low WIDTH bits suffice.
    assign div_hi_n = div_ge ? (div_r[WIDTH-1:0] - opnd_q) : div_r[WIDTH-1:0];
    assign div_lo_n = {lo_q[WIDTH-2:0], div_ge};
`endif

    logic [CW-1:0] cnt_n;
    logic          cnt_last;

    assign cnt_n    = cnt_q + 1'b1;
    assign cnt_last = (cnt_n == CNT_END);

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        zero_d   = zero_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    case (op_i)
                        OP_MUL: begin
                            opnd_d  = a_i;
                            lo_d    = b_i;
                            hi_d    = '0;
                            cnt_d   = '0;
                            state_d = S_MUL;
                        end
`ifdef SEQ_ALU_DIV_EN
                        OP_DIV: begin
                            opnd_d  = b_i;
                            lo_d    = a_i;
                            hi_d    = '0;
                            cnt_d   = '0;
                            state_d = S_DIV;
                        end
`endif
                        default: begin
                            // Includes op 111 when the divider is not built:
                            // simple_res is zero for it.
                            res_d    = simple_res;
                            res_hi_d = '0;
                            zero_d   = (simple_res == '0);
                            done_d   = 1'b1;
                        end
                    endcase
                end
            end

            S_MUL: begin
                hi_d  = mul_hi_n;
                lo_d  = mul_lo_n;
                cnt_d = cnt_n;
                if (cnt_last) begin
                    res_d    = mul_lo_n;
                    res_hi_d = mul_hi_n;
                    zero_d   = (mul_lo_n == '0);
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end

`ifdef SEQ_ALU_DIV_EN
            S_DIV: begin
                hi_d  = div_hi_n;
                lo_d  = div_lo_n;
                cnt_d = cnt_n;
                if (cnt_last) begin
                    res_d    = div_lo_n;
                    res_hi_d = div_hi_n;
                    zero_d   = (div_lo_n == '0);
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign result_o    = res_q;
    assign result_hi_o = res_hi_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu -- directed self-checking bench for seq_alu (WIDTH = 32).
// Expectations for op 111 follow SEQ_ALU_DIV_EN.
// -----------------------------------------------------------------------------
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;

    int tests = 0;
    int fails = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .busy_o      (busy),
        .done_o      (done),
        .result_o    (result),
        .result_hi_o (result_hi),
        .zero_o      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one accepted request; returns in cycle N+1.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
    endtask

    int busy_cnt;
    int done_cnt;

    initial begin
        // ---------------- reset
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_result_hi", result_hi, 32'h0);
        chk("rst_zero", zero, 1'b1);
        rst_n = 1'b1;
        tick();

        // ---------------- simple ops
        issue(3'b000, 32'hFFFF_FFFF, 32'h1);
        chk("add_done", done, 1'b1);
        chk("add_busy", busy, 1'b0);
        chk("add_result", result, 32'h0);
        chk("add_zero", zero, 1'b1);
        tick();
        chk("add_done_pulse", done, 1'b0);

        issue(3'b001, 32'd3, 32'd5);
        chk("sub_result", result, 32'hFFFF_FFFE);
        chk("sub_zero", zero, 1'b0);
        chk("sub_result_hi", result_hi, 32'h0);

        issue(3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk("and_result", result, 32'h00F0_00F0);
        issue(3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk("or_result", result, 32'hFFF0_FFF0);

        // ---------------- shifts (back-to-back simple ops)
        issue(3'b101, 32'h8000_0000, 32'd4);
        chk("sra_4", result, 32'hF800_0000);
        chk("sra_4_done", done, 1'b1);
        issue(3'b101, 32'h8000_0000, 32'd40);
        chk("sra_40", result, 32'hFFFF_FFFF);
        issue(3'b101, 32'h4000_0000, 32'h0000_0100);
        chk("sra_256_pos", result, 32'h0);
        issue(3'b100, 32'h8000_0000, 32'd32);
        chk("srl_32", result, 32'h0);
        chk("srl_32_zero", zero, 1'b1);
        issue(3'b100, 32'h8000_0000, 32'd31);
        chk("srl_31", result, 32'h1);

        // ---------------- mulu FFFFFFFF x 2, with an add pulsed while busy
        issue(3'b110, 32'hFFFF_FFFF, 32'd2);
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (k == 5) begin
                start = 1'b1; op = 3'b000; a = 32'd1; b = 32'd1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("mul_busy_cycles", busy_cnt, 32);
        chk("mul_no_done_while_busy", done_cnt, 0);
        chk("mul_done", done, 1'b1);
        chk("mul_busy_end", busy, 1'b0);
        chk("mul_hi", result_hi, 32'h0000_0001);
        chk("mul_lo", result, 32'hFFFF_FFFE);
        chk("mul_zero", zero, 1'b0);
        tick();
        chk("mul_done_pulse", done, 1'b0);
        chk("mul_lo_held", result, 32'hFFFF_FFFE);

        // ---------------- start held high: operands changed while busy are
        // ignored, next request accepted on the edge that ends done
        start = 1'b1; op = 3'b110; a = 32'd7; b = 32'd6;
        tick();
        op = 3'b000; a = 32'd100; b = 32'd100;
        for (int k = 0; k < 32; k++) tick();
        chk("held_mul_done", done, 1'b1);
        chk("held_mul_lo", result, 32'd42);
        chk("held_mul_hi", result_hi, 32'd0);
        tick();
        start = 1'b0;
        chk("b2b_add_done", done, 1'b1);
        chk("b2b_add_result", result, 32'd200);
        chk("b2b_add_hi", result_hi, 32'd0);
        tick();
        chk("b2b_done_pulse", done, 1'b0);

        // ---------------- divu
`ifdef SEQ_ALU_DIV_EN
        issue(3'b111, 32'd100, 32'd7);
        busy_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            if (busy && !done) busy_cnt++;
            tick();
        end
        chk("div_busy_cycles", busy_cnt, 32);
        chk("div_done", done, 1'b1);
        chk("div_quot", result, 32'd14);
        chk("div_rem", result_hi, 32'd2);

        issue(3'b111, 32'd5, 32'd0);
        for (int k = 0; k < 32; k++) tick();
        chk("div0_done", done, 1'b1);
        chk("div0_quot", result, 32'hFFFF_FFFF);
        chk("div0_rem", result_hi, 32'd5);
`else
        issue(3'b111, 32'd100, 32'd7);
        chk("divoff_done", done, 1'b1);
        chk("divoff_busy", busy, 1'b0);
        chk("divoff_result", result, 32'h0);
        chk("divoff_hi", result_hi, 32'h0);
        chk("divoff_zero", zero, 1'b1);
`endif

        // ---------------- reset in the middle of a mulu
        issue(3'b011, 32'h1234_0000, 32'h0000_5678);
        chk("pre_rst_or", result, 32'h1234_5678);
        issue(3'b110, 32'h0000_FFFF, 32'h0000_FFFF);
        for (int k = 0; k < 9; k++) tick();
        chk("midop_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midop_rst_busy", busy, 1'b0);
        chk("midop_rst_result", result, 32'h0);
        chk("midop_rst_zero", zero, 1'b1);
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("midop_no_done", done_cnt, 0);
        issue(3'b000, 32'd1, 32'd1);
        chk("post_rst_add_done", done, 1'b1);
        chk("post_rst_add_result", result, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
